multicycle_control: RTL

- Moore-style sequencing FSM that turns the single-cycle MIPS datapath into a multi-cycle machine sharing one memory port for instruction fetch and data access.
- Decodes the opcode latched in the instruction register and steps through fetch, decode, execute, memory and writeback, one state per cycle.
- Stalls on a memory ready handshake.
- Drives every datapath mux select and write strobe.
- Sits beside Fetch/Decode/Execute/MEM/WriteBack under the CPU top and replaces the combinational Control block.

---
 rtl/mips_ctrl_pkg.sv | 54 +++++
 rtl/mc_wait_timer.sv | 35 +++
 rtl/multicycle_control.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state encodings and select constants for the multi-cycle MIPS control FSM
package mips_ctrl_pkg;

  // FSM states; encodings are visible on state_dbg and must stay fixed
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC      = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EX   = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_ERROR     = 4'd15
  } state_t;

  // Instruction opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU operation selects
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU A operand selects
  localparam logic SRCA_PC  = 1'b0;
  localparam logic SRCA_REG = 1'b1;

  // ALU B operand selects
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold the memory port and therefore stall on mem_ready
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - consecutive memory wait-cycle counter with timeout detect
module mc_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic ready,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] count;

  // Count stalled cycles; any non-wait state or a completed access clears it,
  // so every entry into a wait state starts from zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!waiting || ready) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // The cycle that would bring the count to WAIT_LIMIT with no ready is the
  // last one tolerated; ready in that same cycle still completes the access
  always_comb begin
    timeout = waiting && !ready && (count == LAST_WAIT);
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS sequencing FSM driving datapath selects and strobes
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] state_dbg,
  output logic       error
);

  state_t state;
  state_t next_state;
  logic   error_q;
  logic   timeout;
  logic   unused_zero;

  // The branch decision (PCWriteCond & zero) is formed in the datapath
  assign unused_zero = zero;

  mc_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (is_wait_state(state)),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  // State register and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_FETCH;
      error_q <= 1'b0;
    end else begin
      state   <= next_state;
      error_q <= error_q || (next_state == ST_ERROR);
    end
  end

  // Next-state decode; ready wins over timeout in the memory states
  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH: begin
        if (mem_ready)    next_state = ST_DECODE;
        else if (timeout) next_state = ST_ERROR;
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state = ST_EXEC;
          OP_LW, OP_SW: next_state = ST_MEM_ADDR;
          OP_BEQ:       next_state = ST_BRANCH;
          OP_J:         next_state = ST_JUMP;
          OP_ADDI:      next_state = ST_ADDI_EX;
          default:      next_state = ST_ERROR;
        endcase
      end
      ST_MEM_ADDR: begin
        next_state = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        if (mem_ready)    next_state = ST_MEM_WB;
        else if (timeout) next_state = ST_ERROR;
      end
      ST_MEM_WB:    next_state = ST_FETCH;
      ST_MEM_WRITE: begin
        if (mem_ready)    next_state = ST_FETCH;
        else if (timeout) next_state = ST_ERROR;
      end
      ST_EXEC:      next_state = ST_R_WB;
      ST_R_WB:      next_state = ST_FETCH;
      ST_BRANCH:    next_state = ST_FETCH;
      ST_JUMP:      next_state = ST_FETCH;
      ST_ADDI_EX:   next_state = ST_ADDI_WB;
      ST_ADDI_WB:   next_state = ST_FETCH;
      ST_ERROR:     next_state = ST_ERROR;
      default:      next_state = ST_ERROR;
    endcase
  end

  // Output decode; Moore except IRWrite/PCWrite in FETCH, and strobes gated by reset
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_B;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    case (state)
      ST_FETCH: begin
        MemRead  = 1'b1;
        IorD     = 1'b0;
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = SRCB_FOUR;
        ALUOp    = ALUOP_ADD;
        PCSource = PCSRC_ALU;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      ST_DECODE: begin
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_IMM_SH2;
        ALUOp   = ALUOP_ADD;
      end
      ST_MEM_ADDR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        RegDst   = 1'b0;
      end
      ST_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_EXEC: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_B;
        ALUOp   = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        MemtoReg = 1'b0;
      end
      ST_BRANCH: begin
        ALUSrcA     = SRCA_REG;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      ST_ADDI_EX: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      ST_ADDI_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  assign state_dbg = state;
  assign error     = error_q;

endmodule
